// File: rtl/scan_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_dump_pkg
// Brief    : Shared types, defaults and helpers for the scan dump engine.
// Revision : 1.0
// ============================================================================
package scan_dump_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    localparam int c_def_num_ch    = 8;
    localparam int c_def_chain_len = 256;
    localparam int c_def_out_w     = 8;

    // $clog2 that never returns 0, so single-entry selects still get a bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_dump_chan.sv
`default_nettype none
// ============================================================================
// Module   : scan_dump_chan
// Brief    : One dump channel: shadow image, word counter, valid/done, mux.
// Revision : 1.0
// ============================================================================
module scan_dump_chan
    import scan_dump_pkg::*;
#(
    parameter  int CHAIN_LEN = c_def_chain_len,
    parameter  int OUT_W     = c_def_out_w,
    localparam int WORDS     = CHAIN_LEN / OUT_W,
    localparam int CNT_W     = clog2_min1(WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_grst_l,
    input  logic                 i_cap,
    input  logic [CHAIN_LEN-1:0] i_cap_data,
    input  logic                 i_cap_en,
    input  logic                 i_rdy,
    output logic [OUT_W-1:0]     o_data,
    output logic                 o_vld,
    output logic                 o_done,
    output logic                 o_en,
    output logic                 o_done_nxt
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WORDS - 1);

    logic [CHAIN_LEN-1:0] r_shadow;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_en;
    logic                 r_done;
    logic                 w_xfer;
    logic                 w_last;
    logic [OUT_W-1:0]     w_word;

    assign o_vld  = r_en & ~r_done;
    assign w_xfer = o_vld & i_rdy;
    assign w_last = (r_cnt == c_last);

    always_ff @(posedge i_clk) begin
        if (!i_grst_l) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_cap) begin
            r_shadow <= i_cap_data;
            r_cnt    <= '0;
            r_en     <= i_cap_en;
            r_done   <= 1'b0;
        end else if (w_xfer) begin
            // Counter parks on the last word; done is what retires the channel.
            if (w_last) begin
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_word = r_shadow[k*OUT_W +: OUT_W];
            end
        end
    end

    assign o_data     = o_vld ? w_word : '0;
    assign o_done     = r_done;
    assign o_en       = r_en;
    assign o_done_nxt = r_done | (w_xfer & w_last);

endmodule
`default_nettype wire

// File: rtl/scan_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_dump_ctrl
// Brief    : Multi-channel shadow-state capture and backpressured dump engine.
// Revision : 1.0
// ============================================================================
module scan_dump_ctrl
    import scan_dump_pkg::*;
#(
    parameter  int NUM_CH    = c_def_num_ch,
    parameter  int CHAIN_LEN = c_def_chain_len,
    parameter  int OUT_W     = c_def_out_w,
    localparam int IDX_W     = $clog2(CHAIN_LEN),
    localparam int CH_W      = clog2_min1(NUM_CH)
) (
    input  logic                        rclk,
    input  logic                        grst_l,
    input  logic [NUM_CH*CHAIN_LEN-1:0] ch_state_in,
    input  logic                        c_en,
    input  logic [NUM_CH-1:0]           dump_en,
    input  logic                        err_en,
    input  logic [CH_W-1:0]             err_ch,
    input  logic [IDX_W-1:0]            err_idx,
    output logic [NUM_CH*OUT_W-1:0]     ch_out,
    output logic [NUM_CH-1:0]           ch_out_vld,
    input  logic [NUM_CH-1:0]           ch_out_rdy,
    output logic [NUM_CH-1:0]           ch_out_done,
    output logic                        busy
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_cap;
    logic                 w_all_done;
    logic                 w_flip_ok;
    logic [CHAIN_LEN-1:0] w_flip_bits;
    logic [NUM_CH-1:0]    w_en;
    logic [NUM_CH-1:0]    w_done_nxt;

    // Widened compares keep the range checks meaningful for any parameter set.
    assign w_flip_ok   = err_en && (32'(err_ch) < NUM_CH) && (32'(err_idx) < CHAIN_LEN);
    assign w_flip_bits = CHAIN_LEN'(1) << err_idx;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            logic [CHAIN_LEN-1:0] w_cap_data;

            assign w_cap_data = ch_state_in[i*CHAIN_LEN +: CHAIN_LEN]
                              ^ ((w_flip_ok && (err_ch == CH_W'(i))) ? w_flip_bits : '0);

            scan_dump_chan #(
                .CHAIN_LEN (CHAIN_LEN),
                .OUT_W     (OUT_W)
            ) u_chan (
                .i_clk      (rclk),
                .i_grst_l   (grst_l),
                .i_cap      (w_cap),
                .i_cap_data (w_cap_data),
                .i_cap_en   (dump_en[i]),
                .i_rdy      (ch_out_rdy[i]),
                .o_data     (ch_out[i*OUT_W +: OUT_W]),
                .o_vld      (ch_out_vld[i]),
                .o_done     (ch_out_done[i]),
                .o_en       (w_en[i]),
                .o_done_nxt (w_done_nxt[i])
            );
        end
    endgenerate

    // Looks one edge ahead so the FSM leaves DUMP on the edge that raises done.
    assign w_all_done = &(~w_en | w_done_nxt);

    always_ff @(posedge rclk) begin
        if (!grst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (c_en) begin
                    w_cap = 1'b1;
                    if (|dump_en) begin
                        w_state_nxt = DUMP;
                    end
                end
            end
            DUMP: begin
                if (w_all_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state == DUMP);

endmodule
`default_nettype wire

// File: doc/scan_dump_ctrl.md
Name: scan_dump_ctrl

Overview:
- Parametrised multi-channel shadow-state dump engine for the debug/scan-inject infrastructure around the FPU pipes (fpu_add and its successors).
- On a capture request it snapshots NUM_CH parallel state images into shadow registers, with an optional single-bit error injection.
- It then streams each enabled channel out as OUT_W-bit words under per-channel valid/ready backpressure.
- It generalises the fixed 8-channel, byte-wide, no-backpressure dump port.

Parameters:
- NUM_CH, 8, number of dump channels.
- CHAIN_LEN, 256, bits of captured state per channel. Must be a multiple of OUT_W.
- OUT_W, 8, width of each channel output word.
- WORDS, CHAIN_LEN/OUT_W (derived), words per channel dump.
- IDX_W, $clog2(CHAIN_LEN) (derived), width of the injection bit index.
- CH_W, max(1,$clog2(NUM_CH)) (derived), width of the injection channel select.

Ports:
- rclk  in  1  clock; all logic on rising edge.
- grst_l  in  1  synchronous, active-low reset.
- ch_state_in  in  NUM_CH*CHAIN_LEN  live state images; channel i occupies [i*CHAIN_LEN +: CHAIN_LEN].
- c_en  in  1  capture request, sampled each cycle.
- dump_en  in  NUM_CH  per-channel dump enable, sampled on an accepted capture.
- err_en  in  1  enable single-bit injection at capture.
- err_ch  in  CH_W  channel receiving the injected flip.
- err_idx  in  IDX_W  bit index to invert.
- ch_out  out  NUM_CH*OUT_W  per-channel output word.
- ch_out_vld  out  NUM_CH  word valid.
- ch_out_rdy  in  NUM_CH  consumer ready.
- ch_out_done  out  NUM_CH  channel dump complete.
- busy  out  1  engine in DUMP state.

Behaviour:
- Reset (grst_l=0 at an edge): state=IDLE. ch_out=0, ch_out_vld=0, ch_out_done=0, busy=0. Word counters and shadow registers cleared. Reset during DUMP aborts the dump immediately, with no further words or done.
- States: IDLE, DUMP.
- IDLE, c_en=1: capture accepted.
  - shadow[i] <= ch_state_in[i] for all i.
  - If err_en=1, err_ch<NUM_CH and err_idx<CHAIN_LEN: shadow[err_ch][err_idx] is inverted. Out-of-range err_ch or err_idx means no flip.
  - en_q <= dump_en. ch_out_done <= 0. Counters <= 0.
  - If dump_en != 0, go to DUMP. Otherwise stay in IDLE; the capture still occurs.
- DUMP:
  - busy=1.
  - For each channel i with en_q[i]=1 and not done: ch_out_vld[i]=1 and ch_out[i]=shadow[i][cnt[i]*OUT_W +: OUT_W], least significant word first.
  - A word transfers when vld[i]&rdy[i]. cnt[i] then increments.
  - Data is held stable while vld=1 and rdy=0.
  - First word is valid the cycle after capture acceptance. Minimum latency is WORDS cycles with rdy held high.
- Last word of channel i accepted (cnt=WORDS-1): next cycle vld[i]=0 and ch_out_done[i]=1. done is held until the next accepted capture or reset.
- Channels advance independently. Ready on one channel never affects another.
- When every en_q channel is done, return to IDLE in the same cycle done rises.
- c_en during DUMP is ignored. No queueing; shadow registers and en_q are unchanged.
- c_en coincident with the final transfer is also ignored. Capture is accepted only in IDLE.
- Channels with en_q[i]=0: vld=0, done=0, ch_out=0.
- ch_out is 0 whenever vld=0.
- Arithmetic: counters are $clog2(WORDS) bits. For WORDS=1, use a 1-bit counter with done on the first transfer. No wrap; the counter stops at WORDS-1.

Decomposition:
- Package scan_dump_pkg holds:
  - state enum (IDLE, DUMP);
  - helper function clog2_min1;
  - localparams for the default NUM_CH, CHAIN_LEN and OUT_W.
- One sub-module, scan_dump_chan, instantiated NUM_CH times via generate. It holds one shadow register, counter, vld/done logic and mux.
- The top level holds the FSM, injection decode and the all-done reduction.

Test Plan:
- NUM_CH=2, CHAIN_LEN=16, OUT_W=8, rdy=2'b11, ch0=16'hA55A, ch1=16'h1234, dump_en=2'b11, c_en pulse -> ch0 emits 5A then A5, ch1 emits 34 then 12 on consecutive cycles. done=2'b11 on cycle 3. busy falls with done.
- Same setup with err_en=1, err_ch=1, err_idx=15 -> ch1 words are 34 then 92. ch0 is unaffected.
- ch0 rdy low for 3 cycles after the first vld -> ch0 holds 5A stable with vld=1. ch1 finishes independently; busy stays 1 until ch0 is done.
- dump_en=2'b01 -> ch1 vld and done remain 0 throughout, and the FSM exits on ch0 done. Then dump_en=0 with c_en -> shadow updated, busy never rises.
- c_en pulsed mid-dump -> output words unchanged from the original capture. A new capture after the return to IDLE clears done and restarts.
- grst_l=0 for 1 cycle mid-dump -> next cycle all outputs 0, state IDLE, no done asserted.
